// File: rtl/addsub_pipe.sv
// -----------------------------------------------------------------------------
// addsub_pipe
//
// Pipelined integer add/subtract unit. The SIZE-bit carry chain is cut into
// STAGES equal segments of W = SIZE/STAGES bits, and one segment is resolved
// per register stage. Operand bits not yet consumed travel down the pipe
// alongside the result bits already produced. Each stage also carries the
// segment carry and the op bit. Valid/ready handshakes are used on both sides.
// Empty stages refill even while the output is stalled.
//
// Ports:
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   in_valid      a/b/op are valid this cycle
//   in_ready      unit accepts a transaction this cycle (combinational)
//   a, b          SIZE-bit operands
//   op            0 = a+b, 1 = a-b
//   out_valid     result valid
//   out_ready     consumer accepts the result
//   out           result modulo 2^SIZE
//   carry_borrow  add: unsigned carry-out; sub: 1 iff unsigned a < b
//   overflow      signed two's-complement overflow
//   zero          out == 0
// -----------------------------------------------------------------------------
module addsub_pipe #(
    parameter int SIZE   = 32,
    parameter int STAGES = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    input  logic            op,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SIZE-1:0] out,
    output logic            carry_borrow,
    output logic            overflow,
    output logic            zero
);

    localparam int W    = (STAGES >= 1) ? SIZE / STAGES : 1;
    localparam int LAST = STAGES - 1;

    if (STAGES < 1 || STAGES > SIZE || (SIZE % STAGES) != 0) begin : g_bad_params
        $error("addsub_pipe: STAGES must satisfy 1 <= STAGES <= SIZE and divide SIZE");
    end

    // Stage occupancy. v[LAST] is the output register's valid bit.
    logic [STAGES-1:0] v;
    logic [STAGES-1:0] adv;   // stage hands its contents downstream this cycle
    logic [STAGES-1:0] load;  // stage may capture new contents this cycle

    // Signals presented by the last segment adder to the output register.
    logic            fin_v;
    logic            fin_op;
    logic            fin_c;
    logic            fin_ovf;
    logic [SIZE-1:0] fin_sum;

    // A stage advances when it holds data and the next stage is empty or
    // advancing itself. The loop walks from the output back toward the input.
    always_comb begin
        // NOTE: give every bit a default first so no path leaves adv unassigned (a latch).
        adv       = '0;
        adv[LAST] = v[LAST] & out_ready;
        for (int k = LAST - 1; k >= 0; k--) begin
            adv[k] = v[k] & (~v[k+1] | adv[k+1]);
        end
    end

    assign load     = ~v | adv;
    assign in_ready = load[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // REM is the number of operand bits still unconsumed when data enters stage k.
        localparam int REM = SIZE - k * W;

        logic                 up_v;
        logic                 up_op;
        logic                 cin;
        logic [REM-1:0]       a_in;
        logic [REM-1:0]       b_in;
        logic [(k+1)*W-1:0]   sum_d;
        logic [W:0]           seg;

        if (k == 0) begin : g_src
            // Subtraction is a + ~b + 1. The +1 enters as the stage-0 carry-in.
            assign up_v  = in_valid;
            assign up_op = op;
            assign cin   = op;
            assign a_in  = a;
            assign b_in  = op ? ~b : b;
            assign sum_d = seg[W-1:0];
        end else begin : g_src
            assign up_v  = v[k-1];
            assign up_op = g_stage[k-1].g_hold.op_q;
            assign cin   = g_stage[k-1].g_hold.c_q;
            assign a_in  = g_stage[k-1].g_hold.a_q;
            assign b_in  = g_stage[k-1].g_hold.b_q;
            assign sum_d = {seg[W-1:0], g_stage[k-1].g_hold.s_q};
        end

        // The lowest unconsumed W bits are always this stage's segment.
        assign seg = {1'b0, a_in[W-1:0]} + {1'b0, b_in[W-1:0]} + {{W{1'b0}}, cin};

        if (k < LAST) begin : g_hold
            logic                 v_q;
            logic                 op_q;
            logic                 c_q;
            logic [REM-W-1:0]     a_q;
            logic [REM-W-1:0]     b_q;
            logic [(k+1)*W-1:0]   s_q;

            // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    // NOTE: the data registers are cleared along with the valid bits, so nothing stale survives a reset.
                    v_q  <= 1'b0;
                    op_q <= 1'b0;
                    c_q  <= 1'b0;
                    a_q  <= '0;
                    b_q  <= '0;
                    s_q  <= '0;
                end else begin
                    if (load[k]) begin
                        v_q <= up_v;
                    end
                    if (load[k] && up_v) begin
                        op_q <= up_op;
                        c_q  <= seg[W];
                        a_q  <= a_in[REM-1:W];
                        b_q  <= b_in[REM-1:W];
                        s_q  <= sum_d;
                    end
                end
            end

            assign v[k] = v_q;
        end else begin : g_tail
            // The carry into the MSB equals a^b^sum at that bit. XOR-ing it
            // with the carry out of the MSB gives signed overflow.
            assign fin_v   = up_v;
            assign fin_op  = up_op;
            assign fin_c   = seg[W];
            assign fin_sum = sum_d;
            assign fin_ovf = a_in[W-1] ^ b_in[W-1] ^ seg[W-1] ^ seg[W];
        end
    end

    // Output register. This is the last pipeline stage. Flags are computed
    // from the full result before it is registered.
    logic            out_v_q;
    logic [SIZE-1:0] out_q;
    logic            cb_q;
    logic            ovf_q;
    logic            z_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_v_q <= 1'b0;
            out_q   <= '0;
            cb_q    <= 1'b0;
            ovf_q   <= 1'b0;
            z_q     <= 1'b0;
        end else begin
            if (load[LAST]) begin
                out_v_q <= fin_v;
            end
            if (load[LAST] && fin_v) begin
                out_q <= fin_sum;
                // For subtraction, a missing carry out means a borrow occurred.
                cb_q  <= fin_c ^ fin_op;
                ovf_q <= fin_ovf;
                z_q   <= (fin_sum == '0);
            end
        end
    end

    assign v[LAST]      = out_v_q;
    assign out_valid    = out_v_q;
    assign out          = out_q;
    assign carry_borrow = cb_q;
    assign overflow     = ovf_q;
    assign zero         = z_q;

endmodule

// File: tb/tb_addsub_pipe.sv
`timescale 1ns/1ps
module tb_addsub_pipe;

    localparam int NDUT  = 5;
    localparam int N_OPS = 1000;

    // Instance 0 is the SIZE=8/STAGES=2 unit used by the directed tests.
    function automatic int cfg_size(int i);
        case (i)
            0:       return 8;
            4:       return 5;
            default: return 32;
        endcase
    endfunction

    function automatic int cfg_stages(int i);
        case (i)
            0:       return 2;
            1:       return 1;
            2:       return 4;
            3:       return 32;
            default: return 5;
        endcase
    endfunction

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid  [NDUT];
    logic        out_ready [NDUT];
    logic        op_i      [NDUT];
    logic [31:0] a_i       [NDUT];
    logic [31:0] b_i       [NDUT];
    logic        in_ready_o  [NDUT];
    logic        out_valid_o [NDUT];
    logic        cb_o        [NDUT];
    logic        ovf_o       [NDUT];
    logic        z_o         [NDUT];
    logic [31:0] out_o       [NDUT];

    int checks;
    int errors;

    logic [34:0] sb_q [NDUT][$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int S = cfg_size(g);
        localparam int T = cfg_stages(g);
        logic [S-1:0] res;

        addsub_pipe #(.SIZE(S), .STAGES(T)) dut (
            .clk          (clk),
            .rst_n        (rst_n),
            .in_valid     (in_valid[g]),
            .in_ready     (in_ready_o[g]),
            .a            (a_i[g][S-1:0]),
            .b            (b_i[g][S-1:0]),
            .op           (op_i[g]),
            .out_valid    (out_valid_o[g]),
            .out_ready    (out_ready[g]),
            .out          (res),
            .carry_borrow (cb_o[g]),
            .overflow     (ovf_o[g]),
            .zero         (z_o[g])
        );
        assign out_o[g] = 32'(res);
    end

    function automatic logic [31:0] mask_of(int sz);
        return 32'((longint'(1) << sz) - 1);
    endfunction

    // Reference model: plain integer arithmetic on unsigned and signed views.
    // Result packing is {carry_borrow, overflow, zero, out[31:0]}.
    function automatic logic [34:0] model(int sz, logic [31:0] x, logic [31:0] y, logic sub);
        longint m, half, ux, uy, sx, sy, ru, rs;
        logic [31:0] res;
        logic cb, ovf;
        m    = (longint'(1) << sz) - 1;
        half = longint'(1) << (sz - 1);
        ux   = longint'(x) & m;
        uy   = longint'(y) & m;
        sx   = (ux >= half) ? ux - (m + 1) : ux;
        sy   = (uy >= half) ? uy - (m + 1) : uy;
        ru   = sub ? ux - uy : ux + uy;
        rs   = sub ? sx - sy : sx + sy;
        res  = 32'(ru & m);
        cb   = sub ? (ux < uy) : (ru > m);
        ovf  = (rs >= half) || (rs < -half);
        return {cb, ovf, (res == 32'd0), res};
    endfunction

    function automatic logic [31:0] rnd_operand(int sz);
        logic [31:0] m;
        m = mask_of(sz);
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return m;
            2:       return 32'(longint'(1) << (sz - 1));
            3:       return 32'((longint'(1) << (sz - 1)) - 1);
            default: return $urandom & m;
        endcase
    endfunction

    function automatic logic [34:0] observed(int i);
        return {cb_o[i], ovf_o[i], z_o[i], out_o[i]};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < NDUT; i++) begin
            checks++;
            if (out_valid_o[i] !== 1'b0 || observed(i) !== 35'd0) begin
                errors++;
                $display("FAIL reset_state dut%0d: valid=%b out/flags=%h, required valid=0 out/flags=0",
                         i, out_valid_o[i], observed(i));
            end
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < NDUT; i++) begin
            checks++;
            if (in_ready_o[i] !== 1'b1) begin
                errors++;
                $display("FAIL reset_in_ready dut%0d: in_ready=%b, required 1", i, in_ready_o[i]);
            end
        end
    endtask

    // Directed vectors on the 8-bit, 2-stage unit: {a, b, op, out, cb, ovf, zero}.
    task automatic test_arith();
        logic [27:0] tbl [5];
        logic [27:0] e;
        int lat;
        tbl = '{
            {8'h05, 8'h03, 1'b1, 8'h02, 1'b0, 1'b0, 1'b0},
            {8'h03, 8'h05, 1'b1, 8'hFE, 1'b1, 1'b0, 1'b0},
            {8'h10, 8'h10, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1},
            {8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0},
            {8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1}
        };
        for (int t = 0; t < 5; t++) begin
            e = tbl[t];
            @(negedge clk);
            out_ready[0] = 1'b1;
            in_valid[0]  = 1'b1;
            a_i[0]       = {24'd0, e[27:20]};
            b_i[0]       = {24'd0, e[19:12]};
            op_i[0]      = e[11];
            @(posedge clk);
            #1 in_valid[0] = 1'b0;
            lat = 1;
            @(negedge clk);
            while (!out_valid_o[0] && lat < 20) begin
                @(posedge clk);
                lat++;
                @(negedge clk);
            end
            checks++;
            if (lat !== 2 || observed(0) !== {e[2], e[1], e[0], 24'd0, e[10:3]}) begin
                errors++;
                $display("FAIL arith_vec%0d: latency=%0d out/flags=%h, required latency=2 out/flags=%h",
                         t, lat, observed(0), {e[2], e[1], e[0], 24'd0, e[10:3]});
            end
        end
        @(negedge clk);
    endtask

    // One isolated op per configuration: result and latency == STAGES.
    task automatic test_latency();
        logic [34:0] exp_v;
        int lat;
        for (int i = 0; i < NDUT; i++) begin
            @(negedge clk);
            out_ready[i] = 1'b1;
            in_valid[i]  = 1'b1;
            a_i[i]       = rnd_operand(cfg_size(i));
            b_i[i]       = rnd_operand(cfg_size(i));
            op_i[i]      = 1'($urandom_range(0, 1));
            exp_v        = model(cfg_size(i), a_i[i], b_i[i], op_i[i]);
            @(posedge clk);
            #1 in_valid[i] = 1'b0;
            lat = 1;
            @(negedge clk);
            while (!out_valid_o[i] && lat < 100) begin
                @(posedge clk);
                lat++;
                @(negedge clk);
            end
            checks++;
            if (lat !== cfg_stages(i) || observed(i) !== exp_v) begin
                errors++;
                $display("FAIL latency_dut%0d: latency=%0d out/flags=%h, required latency=%0d out/flags=%h",
                         i, lat, observed(i), cfg_stages(i), exp_v);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic [34:0] q[$];
        logic [34:0] held;
        logic [34:0] exp_v;
        bit have_held;
        int acc, got, bubbles, cyc;
        acc = 0; got = 0; bubbles = 0; have_held = 1'b0; held = '0;
        // Stall phase: only two ops fit in the 2-stage pipe.
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            out_ready[0] = 1'b0;
            in_valid[0]  = 1'b1;
            a_i[0]       = rnd_operand(8);
            b_i[0]       = rnd_operand(8);
            op_i[0]      = 1'($urandom_range(0, 1));
            #1;
            if (acc == 2) begin
                checks++;
                if (in_ready_o[0] !== 1'b0) begin
                    errors++;
                    $display("FAIL bp_in_ready_full cycle%0d: in_ready=%b, required 0", c, in_ready_o[0]);
                end
            end
            if (out_valid_o[0]) begin
                if (have_held) begin
                    checks++;
                    if (observed(0) !== held) begin
                        errors++;
                        $display("FAIL bp_hold cycle%0d: out/flags=%h, required %h", c, observed(0), held);
                    end
                end else begin
                    held      = observed(0);
                    have_held = 1'b1;
                end
            end
            if (in_ready_o[0]) begin
                q.push_back(model(8, a_i[0], b_i[0], op_i[0]));
                acc++;
            end
        end
        checks++;
        if (acc !== 2) begin
            errors++;
            $display("FAIL bp_accepts: accepted=%0d, required 2", acc);
        end
        // Release: results drain in order at one per cycle while new ops enter.
        cyc = 0;
        while (got < 6 && cyc < 40) begin
            @(negedge clk);
            out_ready[0] = 1'b1;
            in_valid[0]  = (acc < 6);
            a_i[0]       = rnd_operand(8);
            b_i[0]       = rnd_operand(8);
            op_i[0]      = 1'($urandom_range(0, 1));
            #1;
            if (cyc == 0) begin
                checks++;
                if (in_ready_o[0] !== 1'b1) begin
                    errors++;
                    $display("FAIL bp_accept_and_drain: in_ready=%b, required 1", in_ready_o[0]);
                end
            end
            if (in_valid[0] && in_ready_o[0]) begin
                q.push_back(model(8, a_i[0], b_i[0], op_i[0]));
                acc++;
            end
            if (out_valid_o[0]) begin
                checks++;
                exp_v = (q.size() > 0) ? q.pop_front() : 35'h7_FFFF_FFFF;
                if (observed(0) !== exp_v) begin
                    errors++;
                    $display("FAIL bp_result%0d: out/flags=%h, required %h", got, observed(0), exp_v);
                end
                got++;
            end else begin
                bubbles++;
            end
            cyc++;
        end
        checks++;
        if (got !== 6 || bubbles !== 0) begin
            errors++;
            $display("FAIL bp_throughput: results=%0d bubbles=%0d, required results=6 bubbles=0", got, bubbles);
        end
        @(negedge clk);
        in_valid[0] = 1'b0;
    endtask

    task automatic test_reset_midflight();
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            out_ready[0] = 1'b0;
            in_valid[0]  = 1'b1;
            a_i[0]       = 32'h12 + 32'(c);
            b_i[0]       = 32'h34;
            op_i[0]      = 1'b0;
        end
        @(negedge clk);
        in_valid[0] = 1'b0;
        #1;
        checks++;
        if (out_valid_o[0] !== 1'b1 || in_ready_o[0] !== 1'b0) begin
            errors++;
            $display("FAIL midflight_loaded: out_valid=%b in_ready=%b, required out_valid=1 in_ready=0",
                     out_valid_o[0], in_ready_o[0]);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid_o[0] !== 1'b0 || observed(0) !== 35'd0) begin
            errors++;
            $display("FAIL midflight_async_clear: valid=%b out/flags=%h, required valid=0 out/flags=0",
                     out_valid_o[0], observed(0));
        end
        repeat (2) @(negedge clk);
        rst_n        = 1'b1;
        out_ready[0] = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++;
            if (out_valid_o[0] !== 1'b0) begin
                errors++;
                $display("FAIL midflight_ghost cycle%0d: out_valid=%b, required 0", c, out_valid_o[0]);
            end
        end
    endtask

    // Random traffic on every configuration with random valid/ready toggling.
    task automatic test_sweep();
        int sent [NDUT];
        int got  [NDUT];
        bit stalled [NDUT];
        logic [34:0] held [NDUT];
        logic [34:0] exp_v;
        int cyc;
        bit done;
        for (int i = 0; i < NDUT; i++) begin
            sent[i] = 0; got[i] = 0; stalled[i] = 1'b0; held[i] = '0;
            sb_q[i].delete();
        end
        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < 30000) begin
            @(negedge clk);
            for (int i = 0; i < NDUT; i++) begin
                in_valid[i]  = (sent[i] < N_OPS) && ($urandom_range(0, 3) != 0);
                out_ready[i] = ($urandom_range(0, 2) != 0);
                a_i[i]       = rnd_operand(cfg_size(i));
                b_i[i]       = rnd_operand(cfg_size(i));
                op_i[i]      = 1'($urandom_range(0, 1));
            end
            #1;
            done = 1'b1;
            for (int i = 0; i < NDUT; i++) begin
                if (stalled[i]) begin
                    checks++;
                    if (out_valid_o[i] !== 1'b1 || observed(i) !== held[i]) begin
                        errors++;
                        $display("FAIL sweep_hold dut%0d: valid=%b out/flags=%h, required valid=1 out/flags=%h",
                                 i, out_valid_o[i], observed(i), held[i]);
                    end
                end
                if (in_valid[i] && in_ready_o[i]) begin
                    sb_q[i].push_back(model(cfg_size(i), a_i[i], b_i[i], op_i[i]));
                    sent[i]++;
                end
                if (out_valid_o[i] && out_ready[i]) begin
                    checks++;
                    exp_v = (sb_q[i].size() > 0) ? sb_q[i].pop_front() : 35'h7_FFFF_FFFF;
                    if (observed(i) !== exp_v) begin
                        errors++;
                        $display("FAIL sweep_result dut%0d op%0d: out/flags=%h, required %h",
                                 i, got[i], observed(i), exp_v);
                    end
                    got[i]++;
                end
                stalled[i] = out_valid_o[i] && !out_ready[i];
                held[i]    = observed(i);
                if (got[i] < N_OPS) done = 1'b0;
            end
            cyc++;
        end
        for (int i = 0; i < NDUT; i++) begin
            checks++;
            if (got[i] !== N_OPS || sb_q[i].size() !== 0) begin
                errors++;
                $display("FAIL sweep_complete dut%0d: results=%0d pending=%0d, required results=%0d pending=0",
                         i, got[i], sb_q[i].size(), N_OPS);
            end
        end
        @(negedge clk);
        for (int i = 0; i < NDUT; i++) begin
            in_valid[i]  = 1'b0;
            out_ready[i] = 1'b1;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < NDUT; i++) begin
            in_valid[i]  = 1'b0;
            out_ready[i] = 1'b1;
            op_i[i]      = 1'b0;
            a_i[i]       = 32'd0;
            b_i[i]       = 32'd0;
        end
        test_reset();
        test_arith();
        test_latency();
        test_backpressure();
        test_reset_midflight();
        test_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/addsub_pipe.md
Name: addsub_pipe

Overview:
- Parametrised, pipelined integer add/subtract unit with valid/ready handshakes on both sides.
- Breaks the SIZE-bit carry chain into STAGES equal segments, one segment resolved per register stage, for timing closure at wide SIZE.
- Feeds exponent/mantissa datapaths in the FPU. Sustains one operation per cycle under no backpressure.
- Adds signed overflow, zero and unsigned carry/borrow flags, plus per-transaction add/sub mode.

Parameters:
- SIZE, 32, operand/result bit width (>=1).
- STAGES, 4, pipeline stages = carry-chain segments. Constraints: 1 <= STAGES <= SIZE, SIZE % STAGES == 0; violation is an elaboration $error.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- in_valid  input  1  operands/op valid.
- in_ready  output  1  unit accepts a transaction this cycle.
- a  input  SIZE  operand A.
- b  input  SIZE  operand B.
- op  input  1  0 = a+b, 1 = a-b.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out  output  SIZE  result, modulo 2^SIZE.
- carry_borrow  output  1  add: unsigned carry-out; sub: 1 iff unsigned a < b (underflow).
- overflow  output  1  signed (two's complement) overflow.
- zero  output  1  out == 0.

Behaviour:
- Reset: rst_n low clears every stage valid bit and all data/flag registers asynchronously. out_valid=0, out=0, carry_borrow=0, overflow=0, zero=0. in_ready=1 once reset is released.
- Reset mid-operation: all in-flight transactions are discarded; none emerge after release.
- Handshakes:
  - Transfer occurs when valid & ready are both high at a rising edge.
  - out/flags are held stable while out_valid & !out_ready.
  - out_valid never drops without a transfer.
- Arithmetic:
  - Sub is computed as a + ~b + 1: stage 0 carry-in = op, b is inverted when op=1.
  - W = SIZE/STAGES. Stage k adds bits [k*W +: W] plus the carry registered by stage k-1.
  - Operand segments not yet consumed travel down the pipeline; result segments already computed travel with them.
  - Final carry c: carry_borrow = c when op=0, ~c when op=1.
  - overflow = carry into MSB XOR carry out of MSB.
  - zero is computed from the full registered result in the last stage.
- Latency: exactly STAGES cycles from input transfer to out_valid, given no backpressure. STAGES=1 degenerates to a single registered adder.
- Flow control, per stage k:
  - adv_k = v_k & (!v_{k+1} | adv_{k+1}).
  - Last stage: adv = v_last & out_ready.
  - in_ready = !v_0 | adv_0, combinational from out_ready (no skid buffer).
- Throughput: 1 transaction/cycle with out_ready held high. Full pipeline with out_ready low: in_ready=0 and contents frozen. Bubbles collapse: a stalled output does not block empty upstream stages from filling.
- Ordering: results emerge strictly in input order; no drops, no duplicates.
- Simultaneous input accept and output drain in the same cycle on a full pipeline: both occur, and occupancy is unchanged.

Test Plan:
- Basic sub, SIZE=8, STAGES=2: a=0x05, b=0x03, op=1 -> after 2 cycles out_valid=1, out=0x02, carry_borrow=0, overflow=0, zero=0.
- Underflow/wrap: a=0x03, b=0x05, op=1 -> out=0xFE, carry_borrow=1, overflow=0. Then a=0x10, b=0x10, op=1 -> out=0x00, zero=1, carry_borrow=0.
- Cross-segment carry and signed overflow: a=0x7F, b=0x01, op=0 -> out=0x80, overflow=1, carry_borrow=0. a=0xFF, b=0x01, op=0 -> out=0x00, carry_borrow=1, zero=1.
- Backpressure: stream 6 random ops with out_ready=0.
  - in_ready drops after 2 accepts; out stays stable.
  - Release out_ready: all 6 results arrive in order, matching the reference model.
  - Throughput is 1/cycle once flowing.
- Reset mid-flight: assert rst_n=0 with 2 ops in flight -> outputs go to 0 immediately; after release, no result appears for 10 cycles without new input.
- Parameter sweep: SIZE=32 with STAGES in {1, 4, 32}, plus SIZE=5 with STAGES=5, 1000 random ops with random valid/ready toggling -> scoreboard matches a+b / a-b and all flags. Latency = STAGES when out_ready=1.
